// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - ALU/load writeback arbiter feeding the 4-thread RF write port (optional RF_WB_BYPASS_EN)
module rf_wb_arbiter #(
    parameter int MEM_DEPTH    = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          alu_valid,
    output logic                          alu_ready,
    input  logic [1:0]                    alu_thread,
    input  logic [2:0]                    alu_waddr,
    input  logic [63:0]                   alu_wdata,
    input  logic                          mem_valid,
    output logic                          mem_ready,
    input  logic [1:0]                    mem_thread,
    input  logic [2:0]                    mem_waddr,
    input  logic [63:0]                   mem_wdata,
    output logic                          rf_wena,
    output logic [1:0]                    rf_wthread,
    output logic [2:0]                    rf_waddr,
    output logic [63:0]                   rf_wdata,
    output logic [$clog2(MEM_DEPTH):0]    fifo_count,
    output logic                          wb_busy
);

    localparam int AW = $clog2(MEM_DEPTH);
    localparam int CW = AW + 1;
    localparam int PW = 69;
    localparam logic [CW-1:0] DEPTH_C = CW'(MEM_DEPTH);
    localparam logic [3:0]    LIMIT_C = 4'(STARVE_LIMIT);

    // Load FIFO storage: {thread, addr, data}
    logic [PW-1:0] r_mem [MEM_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [3:0]    r_starve;

    // Registered RF write port
    logic          r_wena;
    logic [1:0]    r_wthread;
    logic [2:0]    r_waddr;
    logic [63:0]   r_wdata;

    logic          w_fifo_nonempty;
    logic          w_force_mem;
    logic          w_alu_grant;
    logic          w_fifo_grant;
    logic          w_mem_accept;
    logic          w_bypass;
    logic          w_push;
    logic          w_pop;
    logic [PW-1:0] w_head;
    logic [PW-1:0] w_mem_beat;

    assign w_fifo_nonempty = (r_count != '0);
    assign w_force_mem     = w_fifo_nonempty && (r_starve == LIMIT_C);

    // Readies depend only on reset and registered state, never on this cycle's pop
    assign alu_ready = !rst && !w_force_mem;
    assign mem_ready = !rst && (r_count < DEPTH_C);

    assign w_alu_grant  = alu_valid && alu_ready;
    assign w_fifo_grant = !rst && !w_alu_grant && w_fifo_nonempty;
    assign w_mem_accept = mem_valid && mem_ready;

`ifdef RF_WB_BYPASS_EN
    // An idle arbiter with an empty FIFO forwards the load straight to the output register
    assign w_bypass = w_mem_accept && !w_fifo_nonempty && !w_alu_grant;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_push     = w_mem_accept && !w_bypass;
    assign w_pop      = w_fifo_grant;
    assign w_head     = r_mem[r_rd_ptr];
    assign w_mem_beat = {mem_thread, mem_waddr, mem_wdata};

    // FIFO payload write; contents need no reset because count gates every read
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_mem_beat;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Count ALU wins while loads wait; any load grant or an empty FIFO clears it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve <= '0;
        end else if (!w_fifo_nonempty || w_fifo_grant) begin
            r_starve <= '0;
        end else if (w_alu_grant && (r_starve != LIMIT_C)) begin
            r_starve <= r_starve + 1'b1;
        end
    end

    // Output register: one-beat write enable, payload holds its last value when idle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wena    <= 1'b0;
            r_wthread <= '0;
            r_waddr   <= '0;
            r_wdata   <= '0;
        end else begin
            r_wena <= w_alu_grant || w_fifo_grant || w_bypass;
            if (w_alu_grant) begin
                r_wthread <= alu_thread;
                r_waddr   <= alu_waddr;
                r_wdata   <= alu_wdata;
            end else if (w_fifo_grant) begin
                {r_wthread, r_waddr, r_wdata} <= w_head;
            end else if (w_bypass) begin
                {r_wthread, r_waddr, r_wdata} <= w_mem_beat;
            end
        end
    end

    assign rf_wena    = r_wena;
    assign rf_wthread = r_wthread;
    assign rf_waddr   = r_waddr;
    assign rf_wdata   = r_wdata;
    assign fifo_count = r_count;
    assign wb_busy    = w_fifo_nonempty || r_wena;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - scoreboard bench for rf_wb_arbiter
module tb_rf_wb_arbiter;

    typedef struct packed {
        logic [1:0]  t;
        logic [2:0]  a;
        logic [63:0] d;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic        alu_ready;
    logic [1:0]  alu_thread;
    logic [2:0]  alu_waddr;
    logic [63:0] alu_wdata;
    logic        mem_valid;
    logic        mem_ready;
    logic [1:0]  mem_thread;
    logic [2:0]  mem_waddr;
    logic [63:0] mem_wdata;
    logic        rf_wena;
    logic [1:0]  rf_wthread;
    logic [2:0]  rf_waddr;
    logic [63:0] rf_wdata;
    logic [2:0]  fifo_count;
    logic        wb_busy;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    rf_wb_arbiter #(.MEM_DEPTH(4), .STARVE_LIMIT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_thread (alu_thread),
        .alu_waddr  (alu_waddr),
        .alu_wdata  (alu_wdata),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_thread (mem_thread),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .rf_wena    (rf_wena),
        .rf_wthread (rf_wthread),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .fifo_count (fifo_count),
        .wb_busy    (wb_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [68:0] act, input logic [68:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Monitor: every RF write must match the next expected commit
    always @(negedge clk) begin
        wr_t e;
        if (rf_wena === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got t=%0d a=%0d d=%0h required no write",
                         rf_wthread, rf_waddr, rf_wdata);
            end else begin
                e = exp_q.pop_front();
                chk("wb_payload", {rf_wthread, rf_waddr, rf_wdata}, e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_alu(input logic v, input wr_t w);
        alu_valid  = v;
        alu_thread = w.t;
        alu_waddr  = w.a;
        alu_wdata  = w.d;
    endtask

    task automatic drive_mem(input logic v, input wr_t w);
        mem_valid  = v;
        mem_thread = w.t;
        mem_waddr  = w.a;
        mem_wdata  = w.d;
    endtask

    function automatic wr_t mk(input int t, input int a, input logic [63:0] d);
        wr_t w;
        w.t = 2'(t);
        w.a = 3'(a);
        w.d = d;
        return w;
    endfunction

    initial begin
        wr_t idle;
        wr_t w;
        idle = mk(0, 0, 64'd0);

        // Reset with both requesters active
        rst = 1'b1;
        drive_alu(1'b1, mk(3, 7, 64'h55));
        drive_mem(1'b1, mk(2, 6, 64'h66));
        @(negedge clk);
        chk("rst_wena", 69'(rf_wena), 69'(0));
        chk("rst_count", 69'(fifo_count), 69'(0));
        chk("rst_alu_ready", 69'(alu_ready), 69'(0));
        chk("rst_mem_ready", 69'(mem_ready), 69'(0));
        chk("rst_busy", 69'(wb_busy), 69'(0));
        tick();
        rst = 1'b0;
        drive_alu(1'b0, idle);
        drive_mem(1'b0, idle);
        @(negedge clk);
        chk("post_rst_alu_ready", 69'(alu_ready), 69'(1));
        chk("post_rst_mem_ready", 69'(mem_ready), 69'(1));
        chk("post_rst_wena", 69'(rf_wena), 69'(0));
        chk("post_rst_wdata", 69'(rf_wdata), 69'(0));
        tick();

        // ALU only: one-cycle latency, single-beat enable
        w = mk(2, 5, 64'hDEAD_BEEF_0000_0001);
        exp_q.push_back(w);
        drive_alu(1'b1, w);
        tick();
        drive_alu(1'b0, idle);
        @(negedge clk);
        chk("alu_lat_wena", 69'(rf_wena), 69'(1));
        tick();
        @(negedge clk);
        chk("alu_pulse_end", 69'(rf_wena), 69'(0));
        tick();

        // Fill with ALU blocking the drain, then a forced load, then drain in push order
        for (int i = 0; i < 5; i++) exp_q.push_back(mk(i, 1, 64'hA000_0000_0000_0000 + 64'(i)));
        for (int i = 0; i < 5; i++) exp_q.push_back(mk(i + 1, 6, 64'h1111_0000_0000_0000 + 64'(i)));
        for (int i = 0; i < 4; i++) begin
            drive_alu(1'b1, mk(i, 1, 64'hA000_0000_0000_0000 + 64'(i)));
            drive_mem(1'b1, mk(i + 1, 6, 64'h1111_0000_0000_0000 + 64'(i)));
            @(negedge clk);
            chk("fill_mem_ready", 69'(mem_ready), 69'(1));
            tick();
        end
        drive_alu(1'b1, mk(4, 1, 64'hA000_0000_0000_0004));
        drive_mem(1'b1, mk(5, 6, 64'h1111_0000_0000_0004));
        @(negedge clk);
        chk("full_mem_ready", 69'(mem_ready), 69'(0));
        chk("full_count", 69'(fifo_count), 69'(4));
        tick();
        drive_alu(1'b1, mk(0, 0, 64'hBAD));
        @(negedge clk);
        chk("fill_force_alu_ready", 69'(alu_ready), 69'(0));
        chk("fill_still_full", 69'(mem_ready), 69'(0));
        tick();
        drive_alu(1'b0, idle);
        @(negedge clk);
        chk("mem_ready_after_pop", 69'(mem_ready), 69'(1));
        tick();
        drive_mem(1'b0, idle);
        repeat (8) tick();
        @(negedge clk);
        chk("drain_count", 69'(fifo_count), 69'(0));
        tick();

        // Starvation: one buffered load, continuous ALU traffic
        exp_q.push_back(mk(0, 0, 64'hB000_0000_0000_0000));
        exp_q.push_back(mk(1, 0, 64'hB000_0000_0000_0001));
        exp_q.push_back(mk(2, 0, 64'hB000_0000_0000_0002));
        exp_q.push_back(mk(3, 0, 64'hB000_0000_0000_0003));
        exp_q.push_back(mk(3, 2, 64'h5555_0000_0000_0000));
        exp_q.push_back(mk(0, 0, 64'hB000_0000_0000_0004));
        drive_mem(1'b1, mk(3, 2, 64'h5555_0000_0000_0000));
        tick();
        drive_mem(1'b0, idle);
        for (int i = 0; i < 4; i++) begin
            drive_alu(1'b1, mk(i, 0, 64'hB000_0000_0000_0000 + 64'(i)));
            @(negedge clk);
            chk("starve_alu_ready", 69'(alu_ready), 69'(1));
            tick();
        end
        drive_alu(1'b1, mk(0, 0, 64'hB000_0000_0000_0004));
        @(negedge clk);
        chk("starve_forced", 69'(alu_ready), 69'(0));
        chk("starve_count", 69'(fifo_count), 69'(1));
        chk("starve_busy", 69'(wb_busy), 69'(1));
        tick();
        @(negedge clk);
        chk("starve_resume", 69'(alu_ready), 69'(1));
        tick();
        drive_alu(1'b0, idle);
        repeat (4) tick();

        // Same-register conflict: ALU commits first, load last
        exp_q.push_back(mk(1, 3, 64'hAAAA_AAAA_0000_0001));
        exp_q.push_back(mk(1, 3, 64'h7777_7777_0000_0002));
        drive_alu(1'b1, mk(1, 3, 64'hAAAA_AAAA_0000_0001));
        drive_mem(1'b1, mk(1, 3, 64'h7777_7777_0000_0002));
        tick();
        drive_alu(1'b0, idle);
        drive_mem(1'b0, idle);
        repeat (4) tick();
        @(negedge clk);
        chk("conflict_final_data", 69'(rf_wdata), 69'(64'h7777_7777_0000_0002));
        chk("conflict_final_thread", 69'(rf_wthread), 69'(1));
        chk("conflict_final_addr", 69'(rf_waddr), 69'(3));
        chk("conflict_idle_wena", 69'(rf_wena), 69'(0));
        tick();

        // Load latency through the FIFO: write lands two cycles after the push
        w = mk(2, 4, 64'hC0FF_EE00_0000_0009);
        exp_q.push_back(w);
        drive_mem(1'b1, w);
        tick();
        drive_mem(1'b0, idle);
        @(negedge clk);
        chk("load_lat_e1_wena", 69'(rf_wena), 69'(0));
        chk("load_lat_e1_count", 69'(fifo_count), 69'(1));
        tick();
        @(negedge clk);
        chk("load_lat_e2_wena", 69'(rf_wena), 69'(1));
        tick();
        @(negedge clk);
        chk("load_lat_e3_wena", 69'(rf_wena), 69'(0));
        chk("load_lat_e3_count", 69'(fifo_count), 69'(0));
        tick();

        // Reset mid-operation discards buffered loads
        exp_q.push_back(mk(0, 1, 64'hD000_0000_0000_0001));
        exp_q.push_back(mk(1, 2, 64'hD000_0000_0000_0002));
        drive_alu(1'b1, mk(0, 1, 64'hD000_0000_0000_0001));
        drive_mem(1'b1, mk(2, 3, 64'hE000_0000_0000_0001));
        tick();
        drive_alu(1'b1, mk(1, 2, 64'hD000_0000_0000_0002));
        drive_mem(1'b1, mk(3, 4, 64'hE000_0000_0000_0002));
        tick();
        rst = 1'b1;
        drive_alu(1'b0, idle);
        drive_mem(1'b0, idle);
        @(negedge clk);
        chk("midrst_count_before", 69'(fifo_count), 69'(2));
        chk("midrst_alu_ready", 69'(alu_ready), 69'(0));
        chk("midrst_mem_ready", 69'(mem_ready), 69'(0));
        tick();
        @(negedge clk);
        chk("midrst_wena", 69'(rf_wena), 69'(0));
        chk("midrst_count", 69'(fifo_count), 69'(0));
        chk("midrst_busy", 69'(wb_busy), 69'(0));
        chk("midrst_wdata", 69'(rf_wdata), 69'(0));
        tick();
        rst = 1'b0;
        repeat (6) tick();
        @(negedge clk);
        chk("midrst_stays_empty", 69'(fifo_count), 69'(0));
        chk("scoreboard_empty", 69'(exp_q.size()), 69'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
